// File: rtl/binary_to_bcd_seq.sv
//==============================================================================
// Module   : binary_to_bcd_seq
// Purpose  : Sequential binary to packed-BCD converter (iterative double
//            dabble, one operand bit per clock). Supports two's-complement
//            input with a sign output, a sticky overflow flag when the value
//            does not fit in DIGITS decimal digits, and a leading-zero
//            significance mask for display drivers.
// Ports    : clk          - system clock, rising edge
//            rst_n        - asynchronous active-low reset
//            start        - conversion request, accepted when busy=0
//            signed_mode  - sampled with start; 1 = bin_in is two's complement
//            bin_in       - binary operand, sampled on accepted start
//            busy         - conversion in progress
//            done         - one-cycle pulse, result outputs updated
//            bcd_out      - packed BCD result, digit 0 (ones) in [3:0]
//            sign_out     - result is negative
//            overflow     - magnitude exceeded 10^DIGITS-1
//            digit_sig    - bit i set when digit i or any higher digit != 0
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module binary_to_bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  signed_mode,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  sign_out,
   output logic                  overflow,
   output logic [DIGITS-1:0]     digit_sig
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [WIDTH-1:0] MAG_ONE  = WIDTH'(1);
   localparam logic [DIGITS-1:0] SIG_RESET = DIGITS'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t            state;
   logic [WIDTH-1:0]  mag;        // remaining magnitude bits, MSB shifts out
   logic [BW-1:0]     work;       // working BCD digits
   logic [CW-1:0]     cnt;        // shifts remaining
   logic              sign_l;
   logic              ovf_l;      // sticky overflow for current conversion

   logic [BW-1:0]     adj;
   logic [BW-1:0]     next_work;
   logic              carry;
   logic              any_nz;
   logic [DIGITS-1:0] next_sig;
   logic              negate;

   // Add-3 correction on every digit >= 5, then the shift. The bit leaving
   // the top digit is a decimal carry past the last digit, i.e. overflow.
   always_comb begin
      adj = work;
      for (int i = 0; i < DIGITS; i++) begin
         if (work[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
      end
      carry     = adj[BW-1];
      next_work = {adj[BW-2:0], mag[WIDTH-1]};

      // Significance mask: scan from the top digit downwards.
      any_nz   = 1'b0;
      next_sig = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         any_nz      = any_nz | (next_work[4*i +: 4] != 4'd0);
         next_sig[i] = any_nz;
      end
      next_sig[0] = 1'b1;
   end

   assign negate = signed_mode & bin_in[WIDTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         mag       <= '0;
         work      <= '0;
         cnt       <= '0;
         sign_l    <= 1'b0;
         ovf_l     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         bcd_out   <= '0;
         sign_out  <= 1'b0;
         overflow  <= 1'b0;
         digit_sig <= SIG_RESET;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  mag    <= negate ? (~bin_in + MAG_ONE) : bin_in;
                  sign_l <= negate;
                  work   <= '0;
                  ovf_l  <= 1'b0;
                  cnt    <= CNT_LOAD;
                  busy   <= 1'b1;
                  state  <= ST_SHIFT;
               end else begin
                  state  <= ST_IDLE;
               end
            end

            ST_SHIFT: begin
               work  <= next_work;
               mag   <= mag << 1;
               ovf_l <= ovf_l | carry;
               cnt   <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  state     <= ST_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  bcd_out   <= next_work;
                  overflow  <= ovf_l | carry;
                  digit_sig <= next_sig;
                  // A zero magnitude leaves no digits and no overflow;
                  // never report it as negative.
                  sign_out  <= sign_l & ((next_work != '0) | ovf_l | carry);
               end
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_binary_to_bcd_seq.sv
//==============================================================================
// Module   : tb_binary_to_bcd_seq
// Purpose  : Scoreboard bench for binary_to_bcd_seq. Two instances share all
//            stimulus: one with three digits, one with two digits so that
//            overflow is exercised on the same vectors.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_binary_to_bcd_seq;

   typedef struct packed {
      logic [11:0] b3;
      logic [2:0]  g3;
      logic        o3;
      logic [7:0]  b2;
      logic [1:0]  g2;
      logic        o2;
      logic        s;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        signed_mode;
   logic [7:0]  bin_in;

   logic        busy3, done3, sign3, ovf3;
   logic [11:0] bcd3;
   logic [2:0]  sig3;
   logic        busy2, done2, sign2, ovf2;
   logic [7:0]  bcd2;
   logic [1:0]  sig2;

   int total = 0;
   int bad   = 0;
   int pushes = 0;
   int dc3 = 0;
   int dc2 = 0;
   exp_t q3[$];
   exp_t q2[$];

   always #5 clk = ~clk;

   binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
      .bin_in(bin_in), .busy(busy3), .done(done3), .bcd_out(bcd3),
      .sign_out(sign3), .overflow(ovf3), .digit_sig(sig3)
   );

   binary_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
      .bin_in(bin_in), .busy(busy2), .done(done2), .bcd_out(bcd2),
      .sign_out(sign2), .overflow(ovf2), .digit_sig(sig2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitors: pop and compare whenever a DUT reports a result.
   always @(negedge clk) begin
      if (rst_n && done3) begin
         exp_t e;
         dc3++;
         if (q3.size() == 0) begin
            chk("d3_unexpected_done", 32'(1), 32'(0));
         end else begin
            e = q3.pop_front();
            chk("d3_bcd",  32'(bcd3),  32'(e.b3));
            chk("d3_sign", 32'(sign3), 32'(e.s));
            chk("d3_ovf",  32'(ovf3),  32'(e.o3));
            chk("d3_sig",  32'(sig3),  32'(e.g3));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && done2) begin
         exp_t e;
         dc2++;
         if (q2.size() == 0) begin
            chk("d2_unexpected_done", 32'(1), 32'(0));
         end else begin
            e = q2.pop_front();
            chk("d2_bcd",  32'(bcd2),  32'(e.b2));
            chk("d2_sign", 32'(sign2), 32'(e.s));
            chk("d2_ovf",  32'(ovf2),  32'(e.o2));
            chk("d2_sig",  32'(sig2),  32'(e.g2));
         end
      end
   end

   // Drive a start for one cycle; optionally record the expected result.
   task automatic issue(input logic [7:0] v, input logic sm, input bit push, input exp_t e);
      start       = 1'b1;
      bin_in      = v;
      signed_mode = sm;
      if (push) begin
         q3.push_back(e);
         q2.push_back(e);
         pushes++;
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called on the first negedge after the accepting edge; returns the
   // negedge index at which done was seen.
   task automatic wait_done(output int n);
      n = 1;
      while (!done3 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!done3) chk("done_timeout", 32'(0), 32'(1));
   endtask

   task automatic run(input logic [7:0] v, input logic sm,
                      input logic [11:0] b3, input logic [2:0] g3, input logic o3,
                      input logic [7:0] b2, input logic [1:0] g2, input logic o2,
                      input logic s);
      int n;
      @(negedge clk);
      issue(v, sm, 1'b1, '{b3, g3, o3, b2, g2, o2, s});
      chk("busy_after_start", 32'(busy3), 32'(1));
      wait_done(n);
      chk("latency", 32'(n), 32'(9));
      chk("busy_at_done", 32'(busy3), 32'(0));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy3), 32'(0));
      chk({tag, "_done"}, 32'(done3), 32'(0));
      chk({tag, "_bcd"},  32'(bcd3),  32'(0));
      chk({tag, "_sign"}, 32'(sign3), 32'(0));
      chk({tag, "_ovf"},  32'(ovf3),  32'(0));
      chk({tag, "_sig"},  32'(sig3),  32'(1));
      chk({tag, "_sig2"}, 32'(sig2),  32'(1));
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      start = 1'b0;
      signed_mode = 1'b0;
      bin_in = 8'd0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;

      //   value  sm    bcd3     sig3   o3  bcd2   sig2  o2  sign
      run(8'd255, 1'b0, 12'h255, 3'b111, 0, 8'h55, 2'b11, 1, 0);
      run(8'd100, 1'b0, 12'h100, 3'b111, 0, 8'h00, 2'b01, 1, 0);
      run(8'd99,  1'b0, 12'h099, 3'b011, 0, 8'h99, 2'b11, 0, 0);
      run(8'd10,  1'b0, 12'h010, 3'b011, 0, 8'h10, 2'b11, 0, 0);
      run(8'd9,   1'b0, 12'h009, 3'b001, 0, 8'h09, 2'b01, 0, 0);
      run(8'd0,   1'b0, 12'h000, 3'b001, 0, 8'h00, 2'b01, 0, 0);
      run(8'h80,  1'b1, 12'h128, 3'b111, 0, 8'h28, 2'b11, 1, 1);
      run(8'hFF,  1'b1, 12'h001, 3'b001, 0, 8'h01, 2'b01, 0, 1);
      run(8'h7F,  1'b1, 12'h127, 3'b111, 0, 8'h27, 2'b11, 1, 0);
      run(8'hFF,  1'b0, 12'h255, 3'b111, 0, 8'h55, 2'b11, 1, 0);
      run(8'd0,   1'b1, 12'h000, 3'b001, 0, 8'h00, 2'b01, 0, 0);
      run(8'd200, 1'b0, 12'h200, 3'b111, 0, 8'h00, 2'b01, 1, 0);
      run(8'd99,  1'b0, 12'h099, 3'b011, 0, 8'h99, 2'b11, 0, 0);

      // Start pulsed while busy is ignored and not queued.
      @(negedge clk);
      issue(8'd200, 1'b0, 1'b1, '{12'h200, 3'b111, 1'b0, 8'h00, 2'b01, 1'b1, 1'b0});
      repeat (2) @(negedge clk);
      issue(8'd37, 1'b0, 1'b0, '0);
      start = 1'b0;
      wait_done(n);
      chk("lat_ignored_start", 32'(n), 32'(6));
      repeat (15) @(negedge clk);

      // Start asserted during the DONE cycle: back-to-back conversion.
      @(negedge clk);
      issue(8'd255, 1'b0, 1'b1, '{12'h255, 3'b111, 1'b0, 8'h55, 2'b11, 1'b1, 1'b0});
      wait_done(n);
      issue(8'd42, 1'b0, 1'b1, '{12'h042, 3'b011, 1'b0, 8'h42, 2'b11, 1'b0, 1'b0});
      wait_done(n);
      chk("lat_back_to_back", 32'(n), 32'(9));

      // Reset in the middle of a conversion: no done, outputs cleared.
      @(negedge clk);
      issue(8'd255, 1'b0, 1'b0, '0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("no_done_after_reset", 32'(dc3), 32'(pushes));
      run(8'd5, 1'b0, 12'h005, 3'b001, 0, 8'h05, 2'b01, 0, 0);

      repeat (5) @(negedge clk);
      chk("done_count3", 32'(dc3), 32'(pushes));
      chk("done_count2", 32'(dc2), 32'(pushes));
      chk("queue3_empty", 32'(q3.size()), 32'(0));
      chk("queue2_empty", 32'(q2.size()), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running required finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
